// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and encodings shared by the operand-fetch stage and its
// register file.
//   DW    - datapath width (matches the ALU operand width)
//   NREG  - architectural register count
//   AW    - register address width
//   state_t - operand-fetch FSM encoding
//   shift_t - B-operand shift codes
package cpu_pkg;

  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READ_A = 2'b01,
    ST_READ_B = 2'b10,
    ST_ISSUE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_t;

endpackage

// File: rtl/regfile8x16.sv
// regfile8x16: NREG x DW register file, async-reset clear, one synchronous
// write port and two combinational read ports.
//   clk, rst_n          - clock, async active-low reset (clears every entry)
//   we, waddr, wdata    - write port, committed on the rising edge
//   raddr_a / rdata_a   - read port A
//   raddr_b / rdata_b   - read port B
// A read that hits the address being written this cycle returns wdata, so a
// consumer latching on the same edge sees the new value (write-through).
module regfile8x16
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [NREG-1:0][DW-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage in front of the 16-bit ALU.
//   clk, rst_n                 - clock, async active-low reset
//   req_valid / req_ready      - instruction handshake (ready only in IDLE)
//   req_rn, req_rm, req_rd     - source A, source B, destination registers
//   req_shift, req_use_imm,
//   req_imm, req_aluop         - B-operand shaping and ALU op
//   out_valid / out_ready      - operand handshake toward the ALU
//   Ain, Bin, ALUop, out_rd    - operands, op and destination tag
//   wb_en, wb_addr, wb_data    - register-file write-back port
// Flow: IDLE accepts -> READ_A latches A -> READ_B latches (shifted) B or the
// immediate -> ISSUE holds outputs until out_ready.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rd,
  input  logic [1:0]    req_shift,
  input  logic          req_use_imm,
  input  logic [DW-1:0] req_imm,
  input  logic [1:0]    req_aluop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [1:0]    ALUop,
  output logic [AW-1:0] out_rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  state_t        state_q, state_d;

  // Instruction fields captured on the accept edge; req_* is ignored after.
  logic [AW-1:0] h_rn, h_rm, h_rd;
  shift_t        h_shift;
  logic          h_use_imm;
  logic [DW-1:0] h_imm;
  logic [1:0]    h_aluop;

  logic [DW-1:0] rf_a, rf_b, b_shifted;

  regfile8x16 #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (h_rn),
    .rdata_a (rf_a),
    .raddr_b (h_rm),
    .rdata_b (rf_b)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_READ_A;
      end
      ST_READ_A: state_d = ST_READ_B;
      ST_READ_B: state_d = ST_ISSUE;
      ST_ISSUE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // B-operand shifter; width-preserving, shifted-out bit dropped.
  always_comb begin
    b_shifted = rf_b;
    unique case (h_shift)
      SH_NONE: b_shifted = rf_b;
      SH_LSL:  b_shifted = {rf_b[DW-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, rf_b[DW-1:1]};
      SH_ASR:  b_shifted = {rf_b[DW-1], rf_b[DW-1:1]};
      default: b_shifted = rf_b;
    endcase
  end

  // Holding registers and output operands. Outputs only change in READ_A /
  // READ_B, so they are frozen throughout ISSUE regardless of write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_rn      <= '0;
      h_rm      <= '0;
      h_rd      <= '0;
      h_shift   <= SH_NONE;
      h_use_imm <= 1'b0;
      h_imm     <= '0;
      h_aluop   <= '0;
      Ain       <= '0;
      Bin       <= '0;
      ALUop     <= '0;
      out_rd    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            h_rn      <= req_rn;
            h_rm      <= req_rm;
            h_rd      <= req_rd;
            h_shift   <= shift_t'(req_shift);
            h_use_imm <= req_use_imm;
            h_imm     <= req_imm;
            h_aluop   <= req_aluop;
          end
        end
        ST_READ_A: Ain <= rf_a;
        ST_READ_B: begin
          Bin    <= h_use_imm ? h_imm : b_shifted;
          ALUop  <= h_aluop;
          out_rd <= h_rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed, table-driven bench for operand_fetch plus
// hand-written sequences for hold, forwarding and mid-operation reset.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_rn, req_rm, req_rd;
  logic [1:0]  req_shift;
  logic        req_use_imm;
  logic [15:0] req_imm;
  logic [1:0]  req_aluop;
  logic        out_valid, out_ready;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd),
    .req_shift(req_shift), .req_use_imm(req_use_imm), .req_imm(req_imm),
    .req_aluop(req_aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  rn, rm, rd;
    logic [1:0]  sh;
    logic        ui;
    logic [15:0] imm;
    logic [1:0]  op;
    logic [15:0] ea, eb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns just after the accept edge.
  task automatic start_req(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                           input logic [1:0] sh, input logic ui, input logic [15:0] imm,
                           input logic [1:0] op);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_rn = rn; req_rm = rm; req_rd = rd; req_shift = sh;
    req_use_imm = ui; req_imm = imm; req_aluop = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble request fields: they must be ignored after the accept edge.
    req_rn = ~rn; req_rm = ~rm; req_rd = ~rd; req_shift = ~sh;
    req_use_imm = ~ui; req_imm = ~imm; req_aluop = ~op;
  endtask

  // Waits (bounded) for out_valid at negedges; lat = negedges after accept.
  task automatic wait_issue(output int lat);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    end
    if (!out_valid) begin
      errors++;
      $display("FAIL issue_timeout: got out_valid=0 expected 1 within 10 cycles");
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    start_req(v.rn, v.rm, v.rd, v.sh, v.ui, v.imm, v.op);
    wait_issue(lat);
    chk($sformatf("v%0d_latency", idx), lat, 3);
    chk($sformatf("v%0d_Ain", idx), {16'd0, Ain}, {16'd0, v.ea});
    chk($sformatf("v%0d_Bin", idx), {16'd0, Bin}, {16'd0, v.eb});
    chk($sformatf("v%0d_ALUop", idx), {30'd0, ALUop}, {30'd0, v.op});
    chk($sformatf("v%0d_out_rd", idx), {29'd0, out_rd}, {29'd0, v.rd});
    @(negedge clk);
    chk($sformatf("v%0d_back_idle", idx), {30'd0, req_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [15:0] ha, hb;
    int lat;
    rst_n = 1'b0; req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rd = '0;
    req_shift = '0; req_use_imm = 1'b0; req_imm = '0; req_aluop = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset state
    #12;
    chk("rst_ready_valid", {30'd0, req_ready, out_valid}, 32'b10);
    chk("rst_Ain_Bin", {Ain, Bin}, 32'd0);
    chk("rst_op_rd", {27'd0, ALUop, out_rd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    wr(3'd1, 16'h0007);
    wr(3'd2, 16'h0003);
    wr(3'd3, 16'h8001);
    wr(3'd5, 16'h7FFF);
    wr(3'd6, 16'hFFFF);

    //            rn    rm    rd    sh     ui    imm       op     A        B
    vecs.push_back('{3'd1, 3'd2, 3'd4, 2'b00, 1'b0, 16'h0000, 2'b01, 16'h0007, 16'h0003});
    vecs.push_back('{3'd1, 3'd3, 3'd5, 2'b01, 1'b0, 16'h0000, 2'b00, 16'h0007, 16'h0002});
    vecs.push_back('{3'd2, 3'd3, 3'd6, 2'b10, 1'b0, 16'h0000, 2'b10, 16'h0003, 16'h4000});
    vecs.push_back('{3'd3, 3'd3, 3'd7, 2'b11, 1'b0, 16'h0000, 2'b11, 16'h8001, 16'hC000});
    vecs.push_back('{3'd0, 3'd3, 3'd1, 2'b11, 1'b1, 16'hFFF0, 2'b01, 16'h0000, 16'hFFF0});
    vecs.push_back('{3'd2, 3'd1, 3'd7, 2'b01, 1'b0, 16'h0000, 2'b11, 16'h0003, 16'h000E});
    vecs.push_back('{3'd5, 3'd5, 3'd2, 2'b11, 1'b0, 16'h0000, 2'b00, 16'h7FFF, 16'h3FFF});
    vecs.push_back('{3'd6, 3'd5, 3'd3, 2'b01, 1'b0, 16'h0000, 2'b10, 16'hFFFF, 16'hFFFE});
    vecs.push_back('{3'd6, 3'd6, 3'd0, 2'b10, 1'b0, 16'h0000, 2'b01, 16'hFFFF, 16'h7FFF});
    vecs.push_back('{3'd7, 3'd6, 3'd6, 2'b00, 1'b1, 16'h8000, 2'b00, 16'h0000, 16'h8000});

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Output hold under backpressure, with write-back and new requests ignored.
    out_ready = 1'b0;
    start_req(3'd1, 3'd2, 3'd5, 2'b01, 1'b0, 16'h0000, 2'b10);
    wait_issue(lat);
    chk("hold_Ain0", {16'd0, Ain}, 32'h0007);
    chk("hold_Bin0", {16'd0, Bin}, 32'h0006);
    for (int c = 0; c < 5; c++) begin
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hAAA0 + 16'(c);
      req_valid = 1'b1; req_rn = 3'(c); req_rm = 3'(c + 1); req_aluop = 2'(c);
      @(negedge clk);
      chk($sformatf("hold%0d_ops", c), {Ain, Bin}, {16'h0007, 16'h0006});
      chk($sformatf("hold%0d_tag", c), {27'd0, ALUop, out_rd}, {27'd0, 2'b10, 3'd5});
      chk($sformatf("hold%0d_hs", c), {30'd0, req_ready, out_valid}, 32'b01);
    end
    wb_en = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", {30'd0, req_ready, out_valid}, 32'b10);
    wr(3'd2, 16'h0003);

    // Write-through forward: R4 in READ_A, R5 in READ_B, then a late write to R4.
    out_ready = 1'b0;
    start_req(3'd4, 3'd5, 3'd2, 2'b01, 1'b0, 16'h0000, 2'b01);
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h1234;   // READ_A cycle
    @(posedge clk); #1;
    wb_addr = 3'd5; wb_data = 16'h0F0F;                 // READ_B cycle
    @(posedge clk); #1;
    wb_addr = 3'd4; wb_data = 16'hBEEF;                 // ISSUE cycle
    @(posedge clk); #1;
    wb_en = 1'b0;
    @(negedge clk);
    chk("fwd_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_Ain", {16'd0, Ain}, 32'h1234);
    chk("fwd_Bin_shifted", {16'd0, Bin}, 32'h1E1E);
    out_ready = 1'b1;
    @(negedge clk);
    run_vec('{3'd4, 3'd5, 3'd1, 2'b00, 1'b0, 16'h0000, 2'b00, 16'hBEEF, 16'h0F0F}, 100);

    // Reset during READ_B abandons the instruction and clears the register file.
    start_req(3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 16'h0000, 2'b11);
    @(negedge clk);   // READ_A
    @(negedge clk);   // READ_B
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", {30'd0, req_ready, out_valid}, 32'b10);
    chk("midrst_ops", {Ain, Bin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_hs", {30'd0, req_ready, out_valid}, 32'b10);
    run_vec('{3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h0000}, 200);
    run_vec('{3'd3, 3'd5, 3'd0, 2'b00, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h0000}, 201);
    run_vec('{3'd6, 3'd4, 3'd0, 2'b00, 1'b0, 16'h0000, 2'b01, 16'h0000, 16'h0000}, 202);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
